reg_file: RTL
=============

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter DATA_W, default 32: register and port data width.
REQ-002 Parameter ADDR_W, default 5: register address width; depth = 2**ADDR_W (32).
REQ-003 clk  input  1  rising-edge clock; sole clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 Rd_En  input  1  read request; captures Rs_Addr/Rt_Addr this edge.
REQ-006 Rs_Addr  input  ADDR_W  source register for operand A.
REQ-007 Rt_Addr  input  ADDR_W  source register for operand B.
REQ-008 Wr_En  input  1  write-back enable.
REQ-009 Wr_Addr  input  ADDR_W  write-back destination register.
REQ-010 Wr_Data  input  DATA_W  write-back data (ALU Output).
REQ-011 A  output  DATA_W  registered operand A to ALU_Unit.
REQ-012 B  output  DATA_W  registered operand B to ALU_Unit.
REQ-013 Rd_Valid  output  1  A/B hold data from a read accepted on the previous edge.

Function
REQ-014 Storage: 2**ADDR_W registers, DATA_W bits each.
REQ-015 Register 0 reads as 0 always; writes to address 0 discarded.
REQ-016 Write: at a rising edge with Wr_En=1, reset=0, Wr_Addr!=0, the register at Wr_Addr takes Wr_Data.
REQ-017 Read: at a rising edge with Rd_En=1, reset=0, A takes reg[Rs_Addr] and B takes reg[Rt_Addr]; latency 1 cycle.
REQ-018 Rd_Valid is set to Rd_En at every non-reset edge; it is 1 for exactly the cycles following an accepted read.
REQ-019 Rd_En=0: A and B hold their previous values; Rd_Valid drops to 0.
REQ-020 Rs_Addr equal to Rt_Addr is legal; A and B return identical data.
REQ-021 Same-edge read and write to the same nonzero address: behaviour is set by REQ-026/REQ-027.
REQ-022 Same-edge read and write to different addresses: read returns pre-write contents; the write completes normally.
REQ-023 Back-to-back reads every cycle are supported with no bubbles.

Reset
REQ-024 At a rising edge with reset=1: all registers, A, B and Rd_Valid are 0; Wr_En and Rd_En are ignored that edge.
REQ-025 Reset mid-operation: a write or read presented on the reset edge is lost; normal operation resumes on the first edge with reset=0.

Configuration
REQ-026 Macro REG_FILE_BYPASS_EN defined: a same-edge read of Wr_Addr (nonzero, Wr_En=1) returns Wr_Data on A and/or B (write-through).
REQ-027 Macro REG_FILE_BYPASS_EN undefined: the same case returns the old register contents; the new value is visible from the next read onward.

Structure
REQ-028 A shared package holds DATA_W and ADDR_W defaults and the ZERO_REG address constant (0); the ALU_Unit operand width is taken from the same package.
REQ-029 One sub-module, reg_file_read_port, performs the address select, the zero-register force and the bypass mux; it is instantiated twice, once for Rs and once for Rt.

Verification
REQ-030 Reset, then Rd_En=1 with Rs=5 and Rt=31 -> next cycle A=0, B=0, Rd_Valid=1.
REQ-031 Write r3=32'h10696671 and r4=32'h12345678, then read Rs=3, Rt=4 -> A=32'h10696671, B=32'h12345678 one cycle later.
REQ-032 Write r0=32'hFFFFFFFF, then read Rs=0, Rt=0 -> A=0, B=0.
REQ-033 r7=32'h1 and a same-edge write of r7=32'hABCD0000 with read Rs=7 -> A=32'hABCD0000 with REG_FILE_BYPASS_EN defined, A=32'h1 without it.
REQ-034 Write r9=32'h55 with reset=1 on the same edge -> a later read of r9 returns 0.
REQ-035 Rd_En pattern 1,1,0,1 -> Rd_Valid 1,1,0,1, each one cycle later; A and B hold during the 0 cycle.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared register-file constants.
// Holds the default register/operand widths and the hard-wired zero-register address.
// ALU_OPND_W is the operand width the ALU consumes. The register file takes its
// default data width from it, so A/B always match the ALU inputs.
// Optional feature macro: REG_FILE_BYPASS_EN (write-through on same-edge read/write).
package reg_file_pkg;

    localparam int unsigned REG_DATA_W = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned ALU_OPND_W = REG_DATA_W;
    localparam int unsigned ZERO_REG   = 0;

endpackage : reg_file_pkg

// File: rtl/reg_file_read_port.sv
// One combinational read port of the register file.
// It selects a register by address, forces register 0 to zero, and optionally
// forwards same-edge write data.
// Ports:
//   regs    - current register contents (full array)
//   addr    - register to read
//   wr_en   - write-back enable of the same edge
//   wr_addr - write-back destination of the same edge
//   wr_data - write-back data of the same edge
//   data_c  - combinational read data (registered by the caller)
// Macro REG_FILE_BYPASS_EN: when defined, a read of the register being written
// on the same edge returns wr_data instead of the stale contents.
module reg_file_read_port
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W = ALU_OPND_W,
    parameter int unsigned ADDR_W = REG_ADDR_W
) (
    input  logic [DATA_W-1:0] regs [2**ADDR_W],
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] data_c
);

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic is_zero_c;
    logic hit_c;

    // Address 0 is hard-wired to zero. A write to it can never be forwarded.
    assign is_zero_c = (addr == ADDR_W'(ZERO_REG));
    assign hit_c     = wr_en && (wr_addr == addr) && !is_zero_c;

    // Priority: zero register, then same-edge forwarding, then array contents.
    always_comb begin
        data_c = regs[addr];
        if (is_zero_c) begin
            data_c = '0;
        end else if (BYPASS && hit_c) begin
            data_c = wr_data;
        end
    end

endmodule : reg_file_read_port

// File: rtl/reg_file.sv
// Two-read, one-write register file feeding the ALU operands.
// Register 0 reads as zero. Reads are registered, with one cycle of latency.
// Ports:
//   clk      - rising-edge clock
//   reset    - synchronous active-high reset; clears the registers, A, B and Rd_Valid
//   Rd_En    - read request; Rs_Addr/Rt_Addr are captured on this edge
//   Rs_Addr  - operand A source register
//   Rt_Addr  - operand B source register
//   Wr_En    - write-back enable
//   Wr_Addr  - write-back destination (writes to register 0 are dropped)
//   Wr_Data  - write-back data
//   A, B     - registered operands
//   Rd_Valid - A/B hold data from the read accepted on the previous edge
// Macro REG_FILE_BYPASS_EN: a same-edge read of the register being written
// returns Wr_Data. Without the macro it returns the old contents.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W = ALU_OPND_W,
    parameter int unsigned ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Rd_En,
    input  logic [ADDR_W-1:0] Rs_Addr,
    input  logic [ADDR_W-1:0] Rt_Addr,
    input  logic              Wr_En,
    input  logic [ADDR_W-1:0] Wr_Addr,
    input  logic [DATA_W-1:0] Wr_Data,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic              Rd_Valid
);

    localparam int unsigned DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rs_data_c;
    logic [DATA_W-1:0] rt_data_c;
    logic              wr_ok_c;

    assign wr_ok_c = Wr_En && (Wr_Addr != ADDR_W'(ZERO_REG));

    // Register storage. Entry 0 is never written, so it stays zero after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok_c) begin
            mem[Wr_Addr] <= Wr_Data;
        end
    end

    reg_file_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rs_port (
        .regs    (mem),
        .addr    (Rs_Addr),
        .wr_en   (Wr_En),
        .wr_addr (Wr_Addr),
        .wr_data (Wr_Data),
        .data_c  (rs_data_c)
    );

    reg_file_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rt_port (
        .regs    (mem),
        .addr    (Rt_Addr),
        .wr_en   (Wr_En),
        .wr_addr (Wr_Addr),
        .wr_data (Wr_Data),
        .data_c  (rt_data_c)
    );

    // Operand registers load only on an accepted read and otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            A        <= '0;
            B        <= '0;
            Rd_Valid <= 1'b0;
        end else begin
            Rd_Valid <= Rd_En;
            if (Rd_En) begin
                A <= rs_data_c;
                B <= rt_data_c;
            end
        end
    end

endmodule : reg_file
